// File: rtl/data_path.sv
// data_path: single-bus 32-bit CPU datapath (GPRs, PC/IR/MAR/MDR, Y/Z, HI/LO, I/O ports, 512x32 RAM, CON).
// Define DATAPATH_MULDIV_EN for signed mul/div.
module data_path (
  input  logic        Clock,
  input  logic        clr,
  input  logic [31:0] Mdatain,
  output logic [31:0] MDR_data_out,
  input  logic        PC_out,
  input  logic        ZHigh_out,
  input  logic        ZLow_out,
  input  logic        HI_out,
  input  logic        LO_out,
  input  logic        C_out,
  input  logic        MDR_out,
  input  logic        in_port_out,
  input  logic        R_out,
  input  logic        BA_out,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        R_in,
  input  logic        PC_enable,
  input  logic        IR_enable,
  input  logic        MAR_enable,
  input  logic        MDR_enable,
  input  logic        Y_enable,
  input  logic        Z_enable,
  input  logic        HI_enable,
  input  logic        LO_enable,
  input  logic        IncPC,
  input  logic        Read,
  input  logic        InPort,
  input  logic        RAM_write_enable,
  input  logic        in_port_enable,
  input  logic        out_port_enable,
  input  logic        con_in,
  input  logic [4:0]  opcode
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_AND  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_SHR  = 5'b01001,
    OP_SHRA = 5'b01010,
    OP_SHL  = 5'b01011,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_MUL  = 5'b01111,
    OP_DIV  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010
  } alu_op_e;

  logic [31:0] gpr_q [16];
  logic [31:0] gpr_d [16];
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mar_q, mar_d, mdr_q, mdr_d;
  logic [31:0] y_q, y_d, zhi_q, zhi_d, zlo_q, zlo_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] inport_q, inport_d, outport_q, outport_d;
  logic        con_q, con_d;

  logic [31:0] mem_q [512];
  logic [31:0] mem_rd, bus, c_sext, sel_val;
  logic [3:0]  sel;
  logic [63:0] alu_res, rot_r, rot_l;
  logic [31:0] sra_v;
  logic [4:0]  sh;
  logic        con_cond;

  assign MDR_data_out = mdr_q;
  assign mem_rd       = mem_q[mar_q[8:0]];
  assign c_sext       = {{13{ir_q[18]}}, ir_q[18:0]};

  always_comb begin
    sel = 4'd0;
    if (Gra)      sel = ir_q[26:23];
    else if (Grb) sel = ir_q[22:19];
    else if (Grc) sel = ir_q[18:15];
  end

  assign sel_val = gpr_q[sel];

  always_comb begin
    bus = '0;
    if (MDR_out)          bus = mdr_q;
    else if (PC_out)      bus = pc_q;
    else if (ZLow_out)    bus = zlo_q;
    else if (ZHigh_out)   bus = zhi_q;
    else if (HI_out)      bus = hi_q;
    else if (LO_out)      bus = lo_q;
    else if (in_port_out) bus = inport_q;
    else if (C_out)       bus = c_sext;
    else if (R_out)       bus = sel_val;
    else if (BA_out)      bus = (sel == 4'd0) ? '0 : sel_val;
  end

  // Rotates come from shifting a doubled operand so a zero amount needs no special case.
  assign sh    = bus[4:0];
  assign rot_r = {y_q, y_q} >> sh;
  assign rot_l = {y_q, y_q} << sh;
  assign sra_v = $signed(y_q) >>> sh;

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] mul_a, mul_b, mul_p;
  logic signed [31:0] div_a, div_b, div_q, div_r;
  assign mul_a = {{32{y_q[31]}}, y_q};
  assign mul_b = {{32{bus[31]}}, bus};
  assign mul_p = mul_a * mul_b;
  assign div_a = y_q;
  assign div_b = bus;
  assign div_q = div_a / div_b;
  assign div_r = div_a % div_b;
`endif

  always_comb begin
    alu_res = {32'd0, bus};
    case (opcode)
      OP_ADD, OP_ADDI: alu_res = {32'd0, y_q + bus};
      OP_SUB:          alu_res = {32'd0, y_q - bus};
      OP_AND, OP_ANDI: alu_res = {32'd0, y_q & bus};
      OP_OR, OP_ORI:   alu_res = {32'd0, y_q | bus};
      OP_ROR:          alu_res = {32'd0, rot_r[31:0]};
      OP_ROL:          alu_res = {32'd0, rot_l[63:32]};
      OP_SHR:          alu_res = {32'd0, y_q >> sh};
      OP_SHRA:         alu_res = {32'd0, sra_v};
      OP_SHL:          alu_res = {32'd0, y_q << sh};
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:          alu_res = mul_p;
      OP_DIV:          alu_res = (bus == '0) ? {y_q, 32'd0} : {div_r, div_q};
`endif
      OP_NEG:          alu_res = {32'd0, 32'd0 - bus};
      OP_NOT:          alu_res = {32'd0, ~bus};
      default:         alu_res = {32'd0, bus};
    endcase
  end

  always_comb begin
    case (ir_q[20:19])
      2'b00:   con_cond = (bus == '0);
      2'b01:   con_cond = (bus != '0);
      2'b10:   con_cond = ~bus[31];
      default: con_cond = bus[31];
    endcase
  end

  always_comb begin
    gpr_d = gpr_q;
    if (R_in) gpr_d[sel] = bus;
    pc_d = pc_q;
    if (PC_enable) pc_d = IncPC ? pc_q + 32'd1 : bus;
    ir_d  = IR_enable  ? bus : ir_q;
    mar_d = MAR_enable ? bus : mar_q;
    mdr_d = mdr_q;
    if (MDR_enable) mdr_d = Read ? (InPort ? Mdatain : mem_rd) : bus;
    y_d       = Y_enable ? bus : y_q;
    zhi_d     = Z_enable ? alu_res[63:32] : zhi_q;
    zlo_d     = Z_enable ? alu_res[31:0]  : zlo_q;
    hi_d      = HI_enable ? bus : hi_q;
    lo_d      = LO_enable ? bus : lo_q;
    inport_d  = in_port_enable  ? Mdatain : inport_q;
    outport_d = out_port_enable ? bus : outport_q;
    con_d     = con_in ? con_cond : con_q;
  end

  always_ff @(posedge Clock) begin
    if (clr) begin
      for (int unsigned i = 0; i < 16; i++) gpr_q[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      con_q     <= 1'b0;
    end else begin
      gpr_q     <= gpr_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      y_q       <= y_d;
      zhi_q     <= zhi_d;
      zlo_q     <= zlo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      inport_q  <= inport_d;
      outport_q <= outport_d;
      con_q     <= con_d;
    end
  end

  // RAM keeps its contents across clr; write uses the pre-edge MDR so same-edge reads see old data.
  always_ff @(posedge Clock) begin
    if (RAM_write_enable) mem_q[mar_q[8:0]] <= mdr_q;
  end

  // Out-port has no pin and only MAR[8:0] addresses the RAM.
  logic unused_bits;
  assign unused_bits = ^{ir_q[31:27], mar_q[31:9], outport_q};

endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: register transfers observed through MDR_data_out and CON.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        clr;
  logic [31:0] Mdatain;
  logic [31:0] MDR_data_out;
  logic PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, in_port_out;
  logic R_out, BA_out, Gra, Grb, Grc, R_in;
  logic PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, Z_enable, HI_enable, LO_enable;
  logic IncPC, Read, InPort, RAM_write_enable, in_port_enable, out_port_enable, con_in;
  logic [4:0] opcode;

  data_path dut (
    .Clock(Clock), .clr(clr), .Mdatain(Mdatain), .MDR_data_out(MDR_data_out),
    .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out),
    .LO_out(LO_out), .C_out(C_out), .MDR_out(MDR_out), .in_port_out(in_port_out),
    .R_out(R_out), .BA_out(BA_out), .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in),
    .PC_enable(PC_enable), .IR_enable(IR_enable), .MAR_enable(MAR_enable),
    .MDR_enable(MDR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .HI_enable(HI_enable), .LO_enable(LO_enable), .IncPC(IncPC), .Read(Read),
    .InPort(InPort), .RAM_write_enable(RAM_write_enable), .in_port_enable(in_port_enable),
    .out_port_enable(out_port_enable), .con_in(con_in), .opcode(opcode)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          kind;   // 0: MDR_data_out, 1: CON flag
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];
  logic check_req;
  int   tests = 0;
  int   fails = 0;

  localparam int SRC_PC = 0, SRC_ZLO = 1, SRC_ZHI = 2, SRC_HI = 3, SRC_LO = 4;
  localparam int SRC_INP = 5, SRC_C = 6, SRC_RA = 7, SRC_BA = 8;

  // Reference state of the datapath.
  logic [31:0] reg_m [16];
  logic [31:0] mem_m [512];
  logic [31:0] pc_m, ir_m, mar_m, mdr_m, y_m, zhi_m, zlo_m, hi_m, lo_m, inp_m;
  logic        con_m;

  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int unsigned s;
    s = b[4:0];
    r = a;
    case (op)
      5'd3, 5'd12: return {32'd0, a + b};
      5'd4:        return {32'd0, a - b};
      5'd5, 5'd13: return {32'd0, a & b};
      5'd6, 5'd14: return {32'd0, a | b};
      5'd7: begin repeat (s) r = {r[0], r[31:1]}; return {32'd0, r}; end
      5'd8: begin repeat (s) r = {r[30:0], r[31]}; return {32'd0, r}; end
      5'd9:        return {32'd0, a >> s};
      5'd10: begin repeat (s) r = {r[31], r[31:1]}; return {32'd0, r}; end
      5'd11:       return {32'd0, a << s};
`ifdef DATAPATH_MULDIV_EN
      5'd15: begin
        longint p;
        p = longint'(int'(a)) * longint'(int'(b));
        return p;
      end
      5'd16: begin
        int ia, ib, q, rm;
        if (b == 32'd0) return {a, 32'd0};
        ia = a; ib = b;
        q  = ia / ib;
        rm = ia - q * ib;
        return {rm, q};
      end
`endif
      5'd17:       return {32'd0, 32'd0 - b};
      5'd18:       return {32'd0, ~b};
      default:     return {32'd0, b};
    endcase
  endfunction

  function automatic logic [31:0] sext_c(input logic [31:0] ir);
    return {{13{ir[18]}}, ir[18:0]};
  endfunction

  // Monitor: after any edge with a pending check, compare every queued expectation.
  always begin
    @(posedge Clock);
    if (check_req) begin
      #1;
      while (sb.size() > 0) begin
        sb_t e;
        logic [31:0] act;
        e = sb.pop_front();
        act = (e.kind == 0) ? MDR_data_out : {31'd0, dut.con_q};
        tests++;
        if (act !== e.exp) begin
          fails++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic clear_strobes();
    clr = 0; PC_out = 0; ZHigh_out = 0; ZLow_out = 0; HI_out = 0; LO_out = 0; C_out = 0;
    MDR_out = 0; in_port_out = 0; R_out = 0; BA_out = 0; Gra = 0; Grb = 0; Grc = 0; R_in = 0;
    PC_enable = 0; IR_enable = 0; MAR_enable = 0; MDR_enable = 0; Y_enable = 0; Z_enable = 0;
    HI_enable = 0; LO_enable = 0; IncPC = 0; Read = 0; InPort = 0; RAM_write_enable = 0;
    in_port_enable = 0; out_port_enable = 0; con_in = 0; opcode = 5'd0; check_req = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #3;
    clear_strobes();
  endtask

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    sb_t e;
    e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
    check_req = 1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) reg_m[i] = '0;
    pc_m = 0; ir_m = 0; mar_m = 0; mdr_m = 0; y_m = 0; zhi_m = 0; zlo_m = 0;
    hi_m = 0; lo_m = 0; inp_m = 0; con_m = 0;
  endtask

  task automatic ext_to_mdr(input logic [31:0] v);
    Mdatain = v; InPort = 1; Read = 1; MDR_enable = 1;
    tick();
    mdr_m = v;
  endtask

  task automatic mdr_to_ir();  MDR_out = 1; IR_enable = 1;  tick(); ir_m  = mdr_m; endtask
  task automatic mdr_to_mar(); MDR_out = 1; MAR_enable = 1; tick(); mar_m = mdr_m; endtask
  task automatic mdr_to_hi();  MDR_out = 1; HI_enable = 1;  tick(); hi_m  = mdr_m; endtask
  task automatic mdr_to_lo();  MDR_out = 1; LO_enable = 1;  tick(); lo_m  = mdr_m; endtask

  task automatic set_ir(input logic [31:0] v); ext_to_mdr(v); mdr_to_ir(); endtask

  task automatic set_gpr(input logic [3:0] k, input logic [31:0] v);
    set_ir({5'd0, k, 23'd0});
    ext_to_mdr(v);
    MDR_out = 1; Gra = 1; R_in = 1;
    tick();
    reg_m[k] = v;
  endtask

  task automatic ram_write(input logic [8:0] a, input logic [31:0] v);
    ext_to_mdr({23'd0, a});
    mdr_to_mar();
    ext_to_mdr(v);
    RAM_write_enable = 1;
    tick();
    mem_m[a] = v;
  endtask

  task automatic ram_read(input logic [8:0] a, input string name);
    ext_to_mdr({23'd0, a});
    mdr_to_mar();
    MDR_enable = 1; Read = 1;
    push(0, mem_m[a], name);
    tick();
    mdr_m = mem_m[a];
  endtask

  task automatic observe(input int src, input logic [31:0] exp, input string name);
    case (src)
      SRC_PC:  PC_out = 1;
      SRC_ZLO: ZLow_out = 1;
      SRC_ZHI: ZHigh_out = 1;
      SRC_HI:  HI_out = 1;
      SRC_LO:  LO_out = 1;
      SRC_INP: in_port_out = 1;
      SRC_C:   C_out = 1;
      SRC_RA:  begin Gra = 1; R_out = 1; end
      default: begin Gra = 1; BA_out = 1; end
    endcase
    MDR_enable = 1;
    push(0, exp, name);
    tick();
    mdr_m = exp;
  endtask

  task automatic alu_check(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] z;
    ext_to_mdr(a); mdr_to_hi();
    HI_out = 1; Y_enable = 1; tick(); y_m = hi_m;
    ext_to_mdr(b); mdr_to_lo();
    LO_out = 1; Z_enable = 1; opcode = op; tick();
    z = alu_ref(op, y_m, lo_m);
    zhi_m = z[63:32]; zlo_m = z[31:0];
    observe(SRC_ZLO, zlo_m, $sformatf("alu op%0d zlo", op));
    observe(SRC_ZHI, zhi_m, $sformatf("alu op%0d zhi", op));
  endtask

  // Two-edge fetch, decode-free execution of an immediate-form op, then write-back to ra.
  task automatic fetch_exec_imm();
    PC_out = 1; MAR_enable = 1; MDR_enable = 1; Read = 1;
    @(posedge Clock); #3;
    mar_m = pc_m;
    push(0, mem_m[pc_m[8:0]], "fetch mdr");
    @(posedge Clock); #3;
    clear_strobes();
    mdr_m = mem_m[pc_m[8:0]];
    mdr_to_ir();
    Grb = 1; BA_out = 1; Y_enable = 1; tick();
    y_m = (ir_m[22:19] == 4'd0) ? 32'd0 : reg_m[ir_m[22:19]];
    C_out = 1; Z_enable = 1; opcode = ir_m[31:27]; tick();
    {zhi_m, zlo_m} = alu_ref(ir_m[31:27], y_m, sext_c(ir_m));
    ZLow_out = 1; Gra = 1; R_in = 1; tick();
    reg_m[ir_m[26:23]] = zlo_m;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc0, va, vb;
    int ops[] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 0, 2, 19, 31};
    logic [31:0] con_vals[4];

    clear_strobes();
    Mdatain = '0;
    clr = 1;
    tick();
    model_reset();

    // Preload state, then clear with enables active.
    set_gpr(4'd5, 32'hA5A5_0001);
    ext_to_mdr(32'h1234_5678); mdr_to_hi();
    ext_to_mdr(32'h0BAD_BEEF); mdr_to_lo();
    HI_out = 1; Y_enable = 1; tick(); y_m = hi_m;
    LO_out = 1; Z_enable = 1; opcode = 5'd15; tick();
    {zhi_m, zlo_m} = alu_ref(5'd15, y_m, lo_m);
    Mdatain = 32'h5555_AAAA; in_port_enable = 1; tick(); inp_m = 32'h5555_AAAA;
    PC_enable = 1; IncPC = 1; tick(); pc_m = pc_m + 1;
    set_ir(32'h0008_0000);
    HI_out = 1; con_in = 1; push(1, 32'd1, "con preload"); tick(); con_m = 1;
    ram_write(9'd9, 32'hCAFE_F00D);

    clr = 1; HI_out = 1; PC_enable = 1; IncPC = 1; HI_enable = 1; MDR_enable = 1; Y_enable = 1;
    Z_enable = 1; R_in = 1; con_in = 1; in_port_enable = 1; IR_enable = 1; MAR_enable = 1;
    Mdatain = 32'hFFFF_FFFF;
    push(0, 32'd0, "clr mdr");
    push(1, 32'd0, "clr con");
    tick();
    model_reset();
    observe(SRC_PC,  pc_m,  "clr pc");
    observe(SRC_ZLO, zlo_m, "clr zlo");
    observe(SRC_ZHI, zhi_m, "clr zhi");
    observe(SRC_HI,  hi_m,  "clr hi");
    observe(SRC_LO,  lo_m,  "clr lo");
    observe(SRC_INP, inp_m, "clr inport");
    observe(SRC_C,   sext_c(ir_m), "clr ir");
    LO_out = 1; Z_enable = 1; opcode = 5'd3; tick();
    zlo_m = y_m + lo_m; zhi_m = 0;
    observe(SRC_ZLO, zlo_m, "clr y");
    set_ir({5'd0, 4'd5, 23'd0});
    observe(SRC_RA, reg_m[5], "clr r5");
    ram_read(9'd9, "ram kept across clr");

    // Fetch/execute ori R1,R1,5 then ori R1,R0,5.
    ram_write(9'd0, 32'h7088_0005);
    ram_write(9'd1, 32'h7080_0005);
    set_gpr(4'd1, 32'h0000_0012);
    set_gpr(4'd0, 32'hFFFF_FFFF);
    fetch_exec_imm();
    observe(SRC_RA, reg_m[ir_m[26:23]], "ori r1 result");
    observe(SRC_C,  sext_c(ir_m), "ori c field");
    PC_enable = 1; IncPC = 1; tick(); pc_m = pc_m + 1;
    fetch_exec_imm();
    observe(SRC_RA, reg_m[ir_m[26:23]], "ori rb=r0 result");
    observe(SRC_ZHI, zhi_m, "ori zhi");
    set_ir(32'd0);
    observe(SRC_RA, reg_m[0], "r0 via r_out");
    observe(SRC_BA, 32'd0,    "r0 via ba_out");

    // Sign extension of the C field.
    set_ir(32'h0007_FFFF);
    observe(SRC_C, sext_c(ir_m), "c sext neg");
    set_ir(32'h0003_FFFF);
    observe(SRC_C, sext_c(ir_m), "c sext pos");

    // IncPC held three edges.
    pc0 = pc_m;
    PC_enable = 1; IncPC = 1;
    repeat (3) @(posedge Clock);
    #3; clear_strobes();
    pc_m = pc0 + 3;
    observe(SRC_PC, pc_m, "incpc x3");

    // PC loaded from bus, in-port, bus priority.
    set_ir(32'h0000_0123);
    C_out = 1; PC_enable = 1; tick(); pc_m = sext_c(ir_m);
    observe(SRC_PC, pc_m, "pc from bus");
    Mdatain = $urandom; in_port_enable = 1; tick(); inp_m = Mdatain;
    observe(SRC_INP, inp_m, "inport");
    ext_to_mdr(32'h0F0F_0F0F);
    MDR_out = 1; PC_out = 1; ZLow_out = 1; LO_enable = 1; tick(); lo_m = mdr_m;
    observe(SRC_LO, lo_m, "priority mdr over pc");

    // Same-edge RAM write and read return old data.
    ram_write(9'd20, 32'h1111_2222);
    ext_to_mdr(32'd20); mdr_to_mar();
    ext_to_mdr(32'h3333_4444);
    RAM_write_enable = 1; MDR_enable = 1; Read = 1;
    push(0, mem_m[20], "ram rw same edge old");
    tick();
    mem_m[20] = 32'h3333_4444; mdr_m = 32'h1111_2222;
    MDR_enable = 1; Read = 1;
    push(0, mem_m[20], "ram rw new data");
    tick();
    mdr_m = mem_m[20];

    // Branch condition for each IR[20:19] code.
    for (int c = 0; c < 4; c++) begin
      con_vals[0] = 32'd0; con_vals[1] = 32'd4; con_vals[2] = 32'h8000_0000; con_vals[3] = $urandom;
      for (int j = 0; j < 4; j++) begin
        logic expc;
        ext_to_mdr(con_vals[j]); mdr_to_hi();
        set_ir(32'(c) << 19);
        case (c)
          0: expc = (hi_m == 0);
          1: expc = (hi_m != 0);
          2: expc = (hi_m < 32'h8000_0000);
          default: expc = (hi_m >= 32'h8000_0000);
        endcase
        HI_out = 1; con_in = 1;
        push(1, {31'd0, expc}, $sformatf("con c%0d v%h", c, hi_m));
        tick();
        con_m = expc;
      end
    end

    // ALU: directed corner cases then random.
    alu_check(5'd15, 32'hFFFF_FFFD, 32'd7);
    alu_check(5'd16, 32'd7, 32'd2);
    alu_check(5'd16, 32'hFFFF_FFF9, 32'd2);
    alu_check(5'd16, 32'h1234_5678, 32'd0);
    alu_check(5'd3,  32'hFFFF_FFFF, 32'd1);
    alu_check(5'd7,  32'h8000_0001, 32'd32);
    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      op = 5'(ops[$urandom_range(0, ops.size() - 1)]);
      va = $urandom;
      vb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (op == 5'd16 && va == 32'h8000_0000 && vb == 32'hFFFF_FFFF) vb = 32'd1;
      alu_check(op, va, vb);
    end

    repeat (3) tick();
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
